// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Brief    : 640x480@60 VGA timing (800x525 total) with clock-enable pixel tick.
//            Optional frame_count output under `VGA_TIMING_FRAME_COUNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        pix_tick,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        active_pixels,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_done
`ifdef VGA_TIMING_FRAME_COUNT_EN
    ,
    output logic [15:0] frame_count
`endif
);

    localparam logic [3:0] c_DIV_LAST   = 4'(CLK_DIV - 1);
    localparam logic [9:0] c_H_LAST     = 10'd799;
    localparam logic [9:0] c_V_LAST     = 10'd524;
    localparam logic [9:0] c_H_VISIBLE  = 10'd640;
    localparam logic [9:0] c_V_VISIBLE  = 10'd480;
    localparam logic [9:0] c_HS_START   = 10'd656;
    localparam logic [9:0] c_HS_END     = 10'd751;
    localparam logic [9:0] c_VS_START   = 10'd490;
    localparam logic [9:0] c_VS_END     = 10'd491;

    logic [3:0] r_div;
    logic [9:0] r_h_cnt;
    logic [9:0] r_v_cnt;
    logic [9:0] r_x;
    logic [9:0] r_y;
    logic       r_active;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_frame_done;

    logic       w_tick;
    logic       w_line_end;
    logic       w_frame_end;
    logic       w_active;
    logic       w_hsync;
    logic       w_vsync;

    // With CLK_DIV=1 the divider never leaves 0, so the tick stays high.
    assign w_tick      = (r_div == c_DIV_LAST);
    assign w_line_end  = (r_h_cnt == c_H_LAST);
    assign w_frame_end = w_line_end && (r_v_cnt == c_V_LAST);
    assign w_active    = (r_h_cnt < c_H_VISIBLE) && (r_v_cnt < c_V_VISIBLE);
    assign w_hsync     = !((r_h_cnt >= c_HS_START) && (r_h_cnt <= c_HS_END));
    assign w_vsync     = !((r_v_cnt >= c_VS_START) && (r_v_cnt <= c_VS_END));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div <= 4'd0;
        end else if (w_tick) begin
            r_div <= 4'd0;
        end else begin
            r_div <= r_div + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h_cnt <= 10'd0;
            r_v_cnt <= 10'd0;
        end else if (w_tick) begin
            if (w_line_end) begin
                r_h_cnt <= 10'd0;
                r_v_cnt <= (r_v_cnt == c_V_LAST) ? 10'd0 : r_v_cnt + 10'd1;
            end else begin
                r_h_cnt <= r_h_cnt + 10'd1;
            end
        end
    end

    // Outputs reflect the pre-increment position, one pixel period late.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x      <= 10'd0;
            r_y      <= 10'd0;
            r_active <= 1'b0;
            r_hsync  <= 1'b1;
            r_vsync  <= 1'b1;
        end else if (w_tick) begin
            r_x      <= r_h_cnt;
            r_y      <= r_v_cnt;
            r_active <= w_active;
            r_hsync  <= w_hsync;
            r_vsync  <= w_vsync;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_tick && w_frame_end;
        end
    end

`ifdef VGA_TIMING_FRAME_COUNT_EN
    logic [15:0] r_frame_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_count <= 16'd0;
        end else if (w_tick && w_frame_end) begin
            r_frame_count <= r_frame_count + 16'd1;
        end
    end

    assign frame_count = r_frame_count;
`endif

    assign pix_tick      = w_tick;
    assign x             = r_x;
    assign y             = r_y;
    assign active_pixels = r_active;
    assign hsync         = r_hsync;
    assign vsync         = r_vsync;
    assign frame_done    = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Brief    : Directed scoreboard bench for vga_timing_gen (CLK_DIV=2 and =1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;

    logic       pix_tick, active_pixels, hsync, vsync, frame_done;
    logic [9:0] x, y;
    logic       pix_tick1, active1, hsync1, vsync1, frame_done1;
    logic [9:0] x1, y1;
`ifdef VGA_TIMING_FRAME_COUNT_EN
    logic [15:0] frame_count, frame_count1;
`endif

    vga_timing_gen #(.CLK_DIV(2)) dut (
        .clk(clk), .rst(rst), .pix_tick(pix_tick), .x(x), .y(y),
        .active_pixels(active_pixels), .hsync(hsync), .vsync(vsync),
        .frame_done(frame_done)
`ifdef VGA_TIMING_FRAME_COUNT_EN
        , .frame_count(frame_count)
`endif
    );

    vga_timing_gen #(.CLK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .pix_tick(pix_tick1), .x(x1), .y(y1),
        .active_pixels(active1), .hsync(hsync1), .vsync(vsync1),
        .frame_done(frame_done1)
`ifdef VGA_TIMING_FRAME_COUNT_EN
        , .frame_count(frame_count1)
`endif
    );

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       act;
        logic       hs;
        logic       vs;
    } pix_t;

    localparam pix_t c_RST_PIX = '{x: 10'd0, y: 10'd0, act: 1'b0, hs: 1'b1, vs: 1'b1};

    pix_t       sb_q[$];
    pix_t       last_pix = c_RST_PIX;
    int         n_assert = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         mh = 0;
    int         mv = 0;
    int         dut_ticks = 0;
    int         fd_pulses = 0;
    int         act_row0 = 0;
    int         hs_low_row0 = 0;
    int         vs_low_cnt = 0;
    int         act_blank = 0;
    logic [9:0] jh, jv;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic pix_t model_pix(input int h, input int v);
        pix_t p;
        p.x   = 10'(h);
        p.y   = 10'(v);
        p.act = (h < 640) && (v < 480);
        p.hs  = !((h >= 656) && (h <= 751));
        p.vs  = !((v >= 490) && (v <= 491));
        return p;
    endfunction

    // One clk: tick check at negedge, registered-output check just after posedge.
    task automatic step();
        logic tick_exp;
        logic fd_exp;
        pix_t e;
        @(negedge clk);
        tick_exp = (cyc % 2 == 1);
        check("pix_tick", pix_tick, tick_exp);
        check("pix_tick_div1", pix_tick1, 1'b1);
        if (pix_tick) dut_ticks++;
        fd_exp = 1'b0;
        if (tick_exp) begin
            sb_q.push_back(model_pix(mh, mv));
            fd_exp = (mh == 799) && (mv == 524);
            if (mh == 799) begin
                mh = 0;
                mv = (mv == 524) ? 0 : mv + 1;
            end else begin
                mh++;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        e = (sb_q.size() > 0) ? sb_q.pop_front() : last_pix;
        last_pix = e;
        check("x", x, e.x);
        check("y", y, e.y);
        check("active_pixels", active_pixels, e.act);
        check("hsync", hsync, e.hs);
        check("vsync", vsync, e.vs);
        check("frame_done", frame_done, fd_exp);
        if (frame_done) fd_pulses++;
        if (tick_exp) begin
            if (y == 10'd0 && active_pixels) act_row0++;
            if (y == 10'd0 && !hsync) hs_low_row0++;
            if (!vsync) vs_low_cnt++;
            if (y >= 10'd480 && active_pixels) act_blank++;
        end
    endtask

    // Relocate the DUT's position counters just after an edge to skip ahead.
    task automatic jump(input int h, input int v);
        jh = 10'(h);
        jv = 10'(v);
        force dut.r_h_cnt = jh;
        force dut.r_v_cnt = jv;
        #1;
        release dut.r_h_cnt;
        release dut.r_v_cnt;
        mh = h;
        mv = v;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_x"}, x, 10'd0);
        check({tag, "_y"}, y, 10'd0);
        check({tag, "_active"}, active_pixels, 1'b0);
        check({tag, "_hsync"}, hsync, 1'b1);
        check({tag, "_vsync"}, vsync, 1'b1);
        check({tag, "_frame_done"}, frame_done, 1'b0);
        check({tag, "_pix_tick"}, pix_tick, 1'b0);
        check({tag, "_pix_tick_div1"}, pix_tick1, 1'b1);
    endtask

    initial begin
        // Reset state for both instances
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        check("rst_x_div1", x1, 10'd0);
        check("rst_y_div1", y1, 10'd0);
        check("rst_active_div1", active1, 1'b0);
        check("rst_hsync_div1", hsync1, 1'b1);
        check("rst_vsync_div1", vsync1, 1'b1);
        check("rst_frame_done_div1", frame_done1, 1'b0);

        // Reset release: first tick on 2nd edge, loads (0,0)
        rst = 1'b0;
        cyc = 0;
        step();
        check("first_edge_hold_x", x, 10'd0);
        check("first_edge_active_still_low", active_pixels, 1'b0);
        step();
        check("first_load_active", active_pixels, 1'b1);
        repeat (3) step();
        check("div1_x_after_5_edges", x1, 10'd4);
        check("div1_y_after_5_edges", y1, 10'd0);

        // One full line
        for (int i = 0; i < 2000 && !(y == 10'd1); i++) step();
        check("reach_line1", y, 10'd1);
        check("line1_starts_x0", x, 10'd0);
        check("ticks_per_line", dut_ticks, 801);
        check("active_ticks_row0", act_row0, 640);
        check("hsync_low_ticks_row0", hs_low_row0, 96);

        // Vertical blanking and sync region
        jump(799, 477);
        vs_low_cnt = 0;
        act_blank = 0;
        for (int i = 0; i < 30000 && !(y == 10'd494); i++) step();
        check("reach_line494", y, 10'd494);
        check("vsync_low_ticks", vs_low_cnt, 1600);
        check("active_in_vblank", act_blank, 0);

        // Frame boundary
        jump(790, 524);
        fd_pulses = 0;
        for (int i = 0; i < 200 && !(y == 10'd0 && x == 10'd5); i++) step();
        check("reach_next_frame", {y, x}, {10'd0, 10'd5});
        check("frame_done_pulses", fd_pulses, 1);

        // Asynchronous reset mid-frame at (300,200)
        jump(290, 200);
        fd_pulses = 0;
        for (int i = 0; i < 100 && !(x == 10'd300 && y == 10'd200); i++) step();
        check("reach_300_200", {y, x}, {10'd200, 10'd300});
        #3;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("held_rst");
        rst = 1'b0;
        cyc = 0;
        mh = 0;
        mv = 0;
        sb_q.delete();
        last_pix = c_RST_PIX;
        repeat (8) step();
        check("restart_x", x, 10'd3);
        check("restart_y", y, 10'd0);
        check("no_frame_done_after_abort", fd_pulses, 0);

`ifdef VGA_TIMING_FRAME_COUNT_EN
        check("frame_count_after_reset", frame_count, 16'd0);
        force dut.r_frame_count = 16'hFFFF;
        #1;
        release dut.r_frame_count;
        jump(795, 524);
        for (int i = 0; i < 40 && !(frame_done); i++) step();
        check("frame_done_seen", frame_done, 1'b1);
        check("frame_count_wrap", frame_count, 16'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
